// File: rtl/data_mem_responder_if.sv
// Data-memory port between the pipeline memory stage (master) and the responder (slave).
// Handshake: a request is taken on a rising edge with mem_en=1 and mem_stall=0; mem_rvalid pulses once per taken request.
interface data_mem_responder_if;
    logic        mem_en;
    logic [3:0]  mem_wea;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;
    logic        mem_stall;
    logic        mem_err;

    modport master (
        output mem_en, mem_wea, mem_addr, mem_wdata,
        input  mem_rdata, mem_rvalid, mem_stall, mem_err
    );

    modport slave (
        input  mem_en, mem_wea, mem_addr, mem_wdata,
        output mem_rdata, mem_rvalid, mem_stall, mem_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Word-array responder for the CPU data-memory port: byte-lane writes, write-first read data,
// optional wait states, and misaligned/out-of-range flagging.
module data_mem_responder #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                 clka,
    input  logic                 rst,
    data_mem_responder_if.slave  bus,
    output logic                 dbg_state
);
    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    localparam int         DEPTH    = 1 << ADDR_W;
    localparam bit         NO_WAIT  = (WAIT_CYCLES == 0);
    localparam logic [3:0] CNT_INIT = 4'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

    logic [31:0]       mem_array [DEPTH];
    state_t            state, state_n;
    logic [3:0]        cnt, cnt_n;
    logic              stall_n;
    logic              accept, fire;
    logic [3:0]        lat_wea;
    logic [31:0]       lat_addr, lat_wdata;
    logic [3:0]        acc_wea;
    logic [31:0]       acc_addr, acc_wdata;
    logic [ADDR_W-1:0] acc_idx;
    logic              acc_bad;
    logic [31:0]       old_word, merged;

    assign accept    = bus.mem_en && !bus.mem_stall;
    assign dbg_state = state;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        stall_n = bus.mem_stall;
        fire    = 1'b0;
        if (NO_WAIT) begin
            fire = accept;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        state_n = S_WAIT;
                        cnt_n   = CNT_INIT;
                        stall_n = 1'b1;
                    end
                end
                S_WAIT: begin
                    if (cnt == 4'd0) begin
                        fire    = 1'b1;
                        state_n = S_IDLE;
                        stall_n = 1'b0;
                    end else begin
                        cnt_n = cnt - 4'd1;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    // Zero-wait mode serves the live request; otherwise the copy latched at acceptance.
    always_comb begin
        acc_wea   = NO_WAIT ? bus.mem_wea   : lat_wea;
        acc_addr  = NO_WAIT ? bus.mem_addr  : lat_addr;
        acc_wdata = NO_WAIT ? bus.mem_wdata : lat_wdata;
        acc_idx   = acc_addr[ADDR_W+1:2];
        acc_bad   = (acc_addr[1:0] != 2'b00) || ((acc_addr >> (ADDR_W + 2)) != 32'd0);
        old_word  = mem_array[acc_idx];
        merged    = old_word;
        for (int i = 0; i < 4; i++) begin
            if (acc_wea[i]) merged[8*i +: 8] = acc_wdata[8*i +: 8];
        end
    end

    always_ff @(posedge clka) begin
        if (rst) begin
            state          <= S_IDLE;
            cnt            <= 4'd0;
            bus.mem_stall  <= 1'b0;
            bus.mem_rvalid <= 1'b0;
            bus.mem_rdata  <= 32'd0;
            bus.mem_err    <= 1'b0;
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            bus.mem_stall  <= stall_n;
            bus.mem_rvalid <= fire;
            if (fire) begin
                bus.mem_err   <= acc_bad;
                bus.mem_rdata <= acc_bad ? 32'd0 : merged;
            end
        end
    end

    always_ff @(posedge clka) begin
        if (accept) begin
            lat_wea   <= bus.mem_wea;
            lat_addr  <= bus.mem_addr;
            lat_wdata <= bus.mem_wdata;
        end
    end

    // Array contents survive reset; an access abandoned by reset never writes.
    always_ff @(posedge clka) begin
        if (!rst && fire && !acc_bad && (acc_wea != 4'b0000)) begin
            mem_array[acc_idx] <= merged;
        end
    end
endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder (target) side of the CPU data-memory port.
- Serves the word-wide load/store requests issued by the pipeline's memory stage: enable, byte-lane write enables, byte address, write data.
- Returns read data with a fixed, parameterizable latency, and stalls the initiator while wait states are pending.
- Holds the backing word array and flags misaligned or out-of-range accesses.

Parameters:
- ADDR_W, 10, word-address width; array depth = 2**ADDR_W 32-bit words.
- WAIT_CYCLES, 0, extra wait states per access (0..15); access latency = WAIT_CYCLES+1 edges.

Ports:
- clka  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- mem_en  input  1  request strobe from the initiator.
- mem_wea  input  4  byte-lane write enables; bit i writes wdata[8i+7:8i]; 4'b0000 means read.
- mem_addr  input  32  byte address.
- mem_wdata  input  32  store data.
- mem_rdata  output  32  read data, or merged word after a write.
- mem_rvalid  output  1  one-cycle pulse: access completed, rdata/err valid.
- mem_stall  output  1  responder busy; requests are ignored while high.
- mem_err  output  1  completed access was misaligned or out of range; valid with rvalid.

Behaviour:
- Reset values: mem_rdata=0, mem_rvalid=0, mem_stall=0, mem_err=0, FSM=IDLE, wait counter=0.
  - Array contents are not cleared by reset.
  - Reset mid-access abandons the access; a pending write is never committed.
- Acceptance: a request is accepted at a rising edge where rst=0, mem_en=1 and mem_stall=0. mem_en while stalled is ignored, not queued.
- Decode:
  - Word index = mem_addr[ADDR_W+1:2].
  - Misaligned: mem_addr[1:0]!=0.
  - Out of range: mem_addr[31:ADDR_W+2]!=0.
  - Either error means no array write, rdata=0 and err=1 on completion.
- WAIT_CYCLES=0 (BRAM-like, no FSM dwell):
  - At the accepting edge, the array performs the byte-lane write and registers rdata.
  - rvalid=1 for the following cycle; stall stays 0.
  - Back-to-back requests are accepted every cycle.
- WAIT_CYCLES=N>0, FSM IDLE -> WAIT -> IDLE:
  - Accepting edge E0: latch addr/wea/wdata, stall<=1, counter<=N-1, go to WAIT.
  - In WAIT, each edge decrements the counter. At the edge where counter==0 (edge EN, N edges after E0):
    - perform the array access;
    - stall<=0, rvalid<=1, rdata/err updated;
    - return to IDLE.
  - The next request can be accepted at EN+1.
  - Input changes during WAIT have no effect.
- Write semantics (write-first):
  - Only enabled lanes change.
  - On a write, mem_rdata returns the merged new word.
  - A read accepted after a write completes sees the new data.
- Partial writes: lanes with wea=0 keep their old bytes. Example: wea=4'b0011 changes only bits 15:0.
- rvalid pulses exactly one cycle per accepted request. rdata and err hold their last values until the next completion.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> rdata=0, rvalid=0, stall=0, err=0. With mem_en=0, rvalid stays 0.
- WAIT_CYCLES=0 write/read:
  - write addr=0x10, wea=4'hF, wdata=0xDEADBEEF -> next cycle rvalid=1, rdata=0xDEADBEEF.
  - Immediate read of addr=0x10 -> next cycle rdata=0xDEADBEEF, err=0.
- Byte lanes: word 0x10 holds 0xDEADBEEF; write wea=4'b0100, wdata=0x00AA0000 -> following read returns 0xDEAABEEF.
- Errors:
  - write addr=0x12 (misaligned) -> rvalid=1, err=1, rdata=0; word 0x10 unchanged.
  - With ADDR_W=10, read addr=0x1000 (out of range) -> err=1, rdata=0.
- WAIT_CYCLES=3:
  - read accepted at E0 -> stall=1 for the cycles after E0, E1 and E2; rvalid=1 and stall=0 after E3.
  - mem_en held high during stall with changing addr -> only the latched request completes.
- Reset mid-access (WAIT_CYCLES=3): write 0x12345678 to addr 0x20, assert rst after E1 -> no rvalid. A later read of 0x20 returns the pre-write contents; stall=0 after the reset edge.
